ram_port_arbiter: RTL
=====================

# ram_port_arbiter

Round-robin arbiter that shares port 0 of the dual-port RAM among NUM_REQ requesters of the FIX parser (field writer, tag lookup, checksum reader, and so on). It accepts one read or write per cycle through a valid/ready handshake and drives registered chip-select, write-enable, output-enable, address and data into the RAM. It returns read data to the granted requester with a fixed latency, tagged by a one-hot response strobe. Port 1 of the RAM is not touched by this block.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- ADDR_WIDTH, 8: RAM address width.
- DATA_WIDTH, 32: RAM data width.

Ports (clock and reset first):
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- arb_en  in  1  when low, no new grants are issued; in-flight operations still complete.
- req_valid  in  NUM_REQ  per-requester request pending.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice i.
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_ready  out  NUM_REQ  grant; one-hot or zero; combinational.
- rsp_valid  out  NUM_REQ  one-hot read-data strobe.
- rsp_rdata  out  DATA_WIDTH  read data, shared by all requesters.
- ram_cs, ram_we, ram_oe  out  1 each  RAM port-0 controls.
- ram_addr  out  ADDR_WIDTH  RAM port-0 address.
- ram_wdata  out  DATA_WIDTH  RAM port-0 write data.
- ram_rdata  in  DATA_WIDTH  RAM port-0 read data (registered in the RAM; 0 when not reading).

## Operation
- Handshake: a transfer occurs on a cycle where req_valid[i] and req_ready[i] are both high.
  - A requester holds valid, we, addr and wdata stable until it is granted.
  - req_ready[i] is never high unless req_valid[i] is high.
  - Requesters must not drop valid before the grant; the arbiter does not check for this.
- Arbitration: the search starts at the index given by the pointer rr_ptr and wraps modulo NUM_REQ.
  - The first valid requester found wins.
  - On a grant, rr_ptr becomes (winner+1) mod NUM_REQ.
  - With no grant, rr_ptr holds.
- Grant conditions: no grant when arb_en=0 or rst_n=0. Otherwise one grant per cycle, with no bubbles.
- Command stage (registered): on a grant, the next cycle drives the RAM controls.
  - ram_cs=1, ram_we=req_we.
  - ram_oe = the inverse of req_we.
  - ram_addr and ram_wdata are copied from the winner's slices.
  - ram_wdata is 0 for reads.
  - With no grant, all RAM outputs are 0 the next cycle.
- Response tracking uses a two-stage one-hot id pipeline.
  - Stage 1 holds the winner id for reads only.
  - Stage 2 drives rsp_valid.
  - rsp_rdata = ram_rdata, passed through combinationally while any rsp_valid bit is high, otherwise 0.
- Writes produce no response.
- Back-to-back reads from the same or different requesters each produce their own rsp_valid pulse in grant order.
- A write followed by a read to the same address returns the new data, because the RAM commits the write before the read's command cycle.
- Reset (asynchronous, any time): all outputs go to 0, rr_ptr=0, both id stages are cleared, and in-flight reads are discarded with no rsp_valid.

## Timing
- Cycle N: grant (req_ready high).
- Cycle N+1: RAM command on ram_*.
- Cycle N+2: rsp_valid and rsp_rdata for reads. Read latency is 2 cycles.
- Sustained throughput is 1 operation per cycle.
- Worst-case wait for a continuously valid requester is NUM_REQ-1 cycles.
- arb_en falling in cycle N: no grant in cycle N; reads granted in N-1 and N-2 still respond.

## Configuration
- RAM_ARB_FIXED_PRIO_EN
  - Defined: fixed priority, where the lowest index wins. rr_ptr is removed and index 0 can starve the others.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset: hold rst_n=0 with all req_valid=1. Required: req_ready=0, ram_cs=0, rsp_valid=0.
- Single write then read: requester 2 writes addr 0x10 data 0xDEADBEEF, then reads 0x10. Required: rsp_valid=4'b0100 two cycles after the read grant, with rsp_rdata=0xDEADBEEF.
- Round-robin: all 4 requesters continuously valid for 8 cycles. Required: grant order 0,1,2,3,0,1,2,3 with no idle cycles. With RAM_ARB_FIXED_PRIO_EN defined: 0 every cycle.
- Pipelined reads: requesters 1 then 3 read addresses 0x01 and 0x02, preloaded with 0x11 and 0x22, in consecutive cycles. Required: rsp_valid 4'b0010 with 0x11, then 4'b1000 with 0x22, on consecutive cycles.
- arb_en gating: drop arb_en for 3 cycles while requester 0 is valid. Required: no req_ready during those cycles; a grant in the first cycle after arb_en returns high.
- Reset mid-read: assert rst_n=0 one cycle after a read grant. Required: no rsp_valid afterwards, and after reset release the first grant goes to requester 0.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Shares RAM port 0 among NUM_REQ requesters with one grant per cycle and a fixed two-cycle read latency.
// Optional build macro RAM_ARB_FIXED_PRIO_EN selects lowest-index-wins priority instead of round-robin.
module ram_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          arb_en,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          ram_cs,
  output logic                          ram_we,
  output logic                          ram_oe,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_wdata,
  input  logic [DATA_WIDTH-1:0]         ram_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0]      win_idx_s;
  logic                  win_any_s;
  logic                  grant_fire_s;
  logic [NUM_REQ-1:0]    grant_s;
  logic                  sel_we_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;

  logic                  ram_cs_r;
  logic                  ram_we_r;
  logic                  ram_oe_r;
  logic [ADDR_WIDTH-1:0] ram_addr_r;
  logic [DATA_WIDTH-1:0] ram_wdata_r;
  logic [NUM_REQ-1:0]    rd_id1_r;
  logic [NUM_REQ-1:0]    rsp_valid_r;
  logic [DATA_WIDTH-1:0] rsp_rdata_s;

`ifndef RAM_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]      rr_ptr_r;
  logic [IDX_W-1:0]      rr_ptr_nxt_s;
`endif

  // Winner search: first valid requester from the search start, wrapping around.
  always_comb begin
    int   idx_v;
    logic take_v;
    win_idx_s = {IDX_W{1'b0}};
    win_any_s = 1'b0;
    idx_v     = 0;
    take_v    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      idx_v = k;
`else
      idx_v = (int'(rr_ptr_r) + k) % NUM_REQ;
`endif
      take_v    = req_valid[idx_v] & ~win_any_s;
      win_idx_s = take_v ? IDX_W'(idx_v) : win_idx_s;
      win_any_s = win_any_s | take_v;
    end
  end

  // Grant is suppressed while disabled or while reset is asserted.
  always_comb begin
    grant_fire_s = rst_n & arb_en & win_any_s;
    grant_s      = {NUM_REQ{1'b0}};
    if (grant_fire_s) begin
      grant_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s;
    end else begin
      grant_s = {NUM_REQ{1'b0}};
    end
  end

  assign req_ready = grant_s;

  // Mux the winner's command fields out of the packed request buses.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = {ADDR_WIDTH{1'b0}};
    sel_wdata_s = {DATA_WIDTH{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      sel_we_s    = (win_idx_s == IDX_W'(k)) ? req_we[k] : sel_we_s;
      sel_addr_s  = (win_idx_s == IDX_W'(k)) ? req_addr[k*ADDR_WIDTH +: ADDR_WIDTH] : sel_addr_s;
      sel_wdata_s = (win_idx_s == IDX_W'(k)) ? req_wdata[k*DATA_WIDTH +: DATA_WIDTH] : sel_wdata_s;
    end
  end

`ifndef RAM_ARB_FIXED_PRIO_EN
  // Pointer moves past the winner only when a grant actually fires.
  always_comb begin
    rr_ptr_nxt_s = rr_ptr_r;
    if (grant_fire_s) begin
      rr_ptr_nxt_s = (win_idx_s == IDX_W'(NUM_REQ-1)) ? {IDX_W{1'b0}} : (win_idx_s + IDX_W'(1));
    end else begin
      rr_ptr_nxt_s = rr_ptr_r;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= {IDX_W{1'b0}};
    end else begin
      rr_ptr_r <= rr_ptr_nxt_s;
    end
  end
`endif

  // Command stage and the read-id pipeline; reset drops any read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_cs_r    <= 1'b0;
      ram_we_r    <= 1'b0;
      ram_oe_r    <= 1'b0;
      ram_addr_r  <= {ADDR_WIDTH{1'b0}};
      ram_wdata_r <= {DATA_WIDTH{1'b0}};
      rd_id1_r    <= {NUM_REQ{1'b0}};
      rsp_valid_r <= {NUM_REQ{1'b0}};
    end else begin
      ram_cs_r    <= grant_fire_s;
      ram_we_r    <= grant_fire_s & sel_we_s;
      ram_oe_r    <= grant_fire_s & ~sel_we_s;
      ram_addr_r  <= grant_fire_s ? sel_addr_s : {ADDR_WIDTH{1'b0}};
      ram_wdata_r <= (grant_fire_s & sel_we_s) ? sel_wdata_s : {DATA_WIDTH{1'b0}};
      rd_id1_r    <= (grant_fire_s & ~sel_we_s) ? grant_s : {NUM_REQ{1'b0}};
      rsp_valid_r <= rd_id1_r;
    end
  end

  // Read data is only forwarded alongside a response strobe.
  always_comb begin
    rsp_rdata_s = {DATA_WIDTH{1'b0}};
    if (|rsp_valid_r) begin
      rsp_rdata_s = ram_rdata;
    end else begin
      rsp_rdata_s = {DATA_WIDTH{1'b0}};
    end
  end

  assign ram_cs    = ram_cs_r;
  assign ram_we    = ram_we_r;
  assign ram_oe    = ram_oe_r;
  assign ram_addr  = ram_addr_r;
  assign ram_wdata = ram_wdata_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_s;

endmodule
